// File: rtl/hazard_unit_param.sv
// Pipeline hazard controller: shift-register scoreboard of post-decode slots driving
// load-use stall, redirect flush and EX forwarding selects. HAZARD_PERF_EN adds stall/flush counters.

module hazard_wr_match #(
  parameter int REG_AW = 5
)(
  input  logic              valid,
  input  logic              we,
  input  logic [REG_AW-1:0] rd,
  input  logic [REG_AW-1:0] addr,
  output logic              hit
);
  // x0 is hardwired zero: it never produces a hazard or a bypass
  assign hit = valid & we & (rd == addr) & (addr != '0);
endmodule

module hazard_unit_param #(
  parameter int DEPTH    = 3,
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  localparam int FWD_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
)(
  input  logic              clock,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_we,
  input  logic              id_is_load,
  input  logic              ex_redirect,
  output logic              stall,
  output logic              flush,
  output logic [DEPTH-1:0]  slot_valid,
  output logic [FWD_W-1:0]  fwd_rs1,
  output logic [FWD_W-1:0]  fwd_rs2
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              we;
  } dst_t;

  typedef struct packed {
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              rs1_used;
    logic              rs2_used;
  } src_t;

  logic [DEPTH-1:0]      vld_pipe;
  dst_t [DEPTH-1:0]      dst_q;
  logic [LOAD_LAT-1:0]   ld_pipe;   // load flag only matters while a load is still too young to bypass
  src_t                  src_q;

  logic [LOAD_LAT-1:0]   id1_hit, id2_hit;
  logic [DEPTH-1:1]      ex1_hit, ex2_hit;
  logic                  redir, ld_use;
  logic [FWD_W-1:0]      fwd1_c, fwd2_c;

  for (genvar k = 0; k < LOAD_LAT; k++) begin : g_ld
    hazard_wr_match #(.REG_AW(REG_AW)) u_id1 (
      .valid(vld_pipe[k]), .we(dst_q[k].we), .rd(dst_q[k].rd), .addr(id_rs1), .hit(id1_hit[k]));
    hazard_wr_match #(.REG_AW(REG_AW)) u_id2 (
      .valid(vld_pipe[k]), .we(dst_q[k].we), .rd(dst_q[k].rd), .addr(id_rs2), .hit(id2_hit[k]));
  end

  for (genvar k = 1; k < DEPTH; k++) begin : g_fwd
    hazard_wr_match #(.REG_AW(REG_AW)) u_ex1 (
      .valid(vld_pipe[k]), .we(dst_q[k].we), .rd(dst_q[k].rd), .addr(src_q.rs1), .hit(ex1_hit[k]));
    hazard_wr_match #(.REG_AW(REG_AW)) u_ex2 (
      .valid(vld_pipe[k]), .we(dst_q[k].we), .rd(dst_q[k].rd), .addr(src_q.rs2), .hit(ex2_hit[k]));
  end

  always_comb begin
    ld_use = 1'b0;
    for (int k = 0; k < LOAD_LAT; k++)
      ld_use = ld_use | (ld_pipe[k] & ((id1_hit[k] & id_rs1_used) | (id2_hit[k] & id_rs2_used)));
  end

  // Scan oldest to youngest so the youngest producer overwrites
  always_comb begin
    fwd1_c = '0;
    fwd2_c = '0;
    for (int k = DEPTH-1; k >= 1; k--) begin
      if (ex1_hit[k]) fwd1_c = FWD_W'(k);
      if (ex2_hit[k]) fwd2_c = FWD_W'(k);
    end
  end

  assign redir      = ex_redirect & vld_pipe[0];
  assign flush      = ~reset & redir;
  assign stall      = ~reset & ~redir & id_valid & ld_use;
  assign slot_valid = reset ? '0 : vld_pipe;
  assign fwd_rs1    = (~reset & vld_pipe[0] & src_q.rs1_used) ? fwd1_c : '0;
  assign fwd_rs2    = (~reset & vld_pipe[0] & src_q.rs2_used) ? fwd2_c : '0;

  always_ff @(posedge clock) begin
    if (reset) vld_pipe <= '0;
    else       vld_pipe <= {vld_pipe[DEPTH-2:0], id_valid & ~stall & ~flush};
  end

  // Payload needs no reset: every consumer is qualified by vld_pipe
  always_ff @(posedge clock) begin
    dst_q      <= {dst_q[DEPTH-2:0], dst_t'{rd: id_rd, we: id_we}};
    src_q      <= src_t'{rs1: id_rs1, rs2: id_rs2, rs1_used: id_rs1_used, rs2_used: id_rs2_used};
    ld_pipe[0] <= id_is_load;
    for (int k = LOAD_LAT-1; k >= 1; k--) ld_pipe[k] <= ld_pipe[k-1];
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + {31'b0, stall};
      flush_cnt <= flush_cnt + {31'b0, flush};
    end
  end
`endif

endmodule

// File: tb/tb_hazard_unit_param.sv
// Random + directed bench for hazard_unit_param; two configs (DEPTH 3/LAT 1, DEPTH 5/LAT 2)
// checked against an instruction-history reference model.

module tb_hazard_unit_param;
  localparam int NC = 2600;

  logic       clock = 1'b0;
  logic       reset, id_valid, id_rs1_used, id_rs2_used, id_we, id_is_load, ex_redirect;
  logic [4:0] id_rs1, id_rs2, id_rd;

  logic       st3, fl3, st5, fl5;
  logic [2:0] sv3;
  logic [4:0] sv5;
  logic [1:0] f1_3, f2_3;
  logic [2:0] f1_5, f2_5;
`ifdef HAZARD_PERF_EN
  logic [31:0] sc3, fc3, sc5, fc5;
`endif

  always #5 clock = ~clock;

  hazard_unit_param #(.DEPTH(3), .REG_AW(5), .LOAD_LAT(1)) u_d3 (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_we(id_we),
    .id_is_load(id_is_load), .ex_redirect(ex_redirect), .stall(st3), .flush(fl3),
    .slot_valid(sv3), .fwd_rs1(f1_3), .fwd_rs2(f2_3)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(sc3), .flush_cnt(fc3)
`endif
  );

  hazard_unit_param #(.DEPTH(5), .REG_AW(5), .LOAD_LAT(2)) u_d5 (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_we(id_we),
    .id_is_load(id_is_load), .ex_redirect(ex_redirect), .stall(st5), .flush(fl5),
    .slot_valid(sv5), .fwd_rs1(f1_5), .fwd_rs2(f2_5)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(sc5), .flush_cnt(fc5)
`endif
  );

  // One record per instruction that entered EX; slot k at cycle c is whatever entered at c-k
  typedef struct packed {
    bit v; int rd; bit we; bit ld; int rs1; int rs2; bit u1; bit u2;
  } ent_t;

  ent_t hist [2][NC];
  int   rst_mark [2];
  int   cnt_st [2], cnt_fl [2];
  int   cyc, n_vec, n_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic ent_t slot_at(int cfg, int k);
    ent_t e;
    e = '0;
    if (cyc - k >= rst_mark[cfg] && cyc - k >= 0) e = hist[cfg][cyc-k];
    return e;
  endfunction

  function automatic bit writes(ent_t e, int r);
    return e.v && e.we && e.rd == r && r != 0;
  endfunction

  task automatic model_check(input int cfg);
    int   d, ll, e1, e2;
    bit   redir, e_st, e_fl;
    ent_t ex, s, nx;
    logic [31:0] e_sv, g_sv, g_st, g_fl, g_f1, g_f2;
    d  = cfg ? 5 : 3;
    ll = cfg ? 2 : 1;
    ex = slot_at(cfg, 0);
    redir = ex_redirect && ex.v;
    e_st = 1'b0;
    for (int k = 0; k < ll; k++) begin
      s = slot_at(cfg, k);
      if (s.v && s.ld && ((id_rs1_used && writes(s, id_rs1)) || (id_rs2_used && writes(s, id_rs2))))
        e_st = 1'b1;
    end
    e_st = e_st && id_valid && !redir && !reset;
    e_fl = redir && !reset;
    e1 = 0; e2 = 0;
    e_sv = 0;
    for (int k = 0; k < d; k++) if (slot_at(cfg, k).v && !reset) e_sv[k] = 1'b1;
    if (ex.v && !reset) begin
      for (int k = 1; k < d; k++) begin
        if (ex.u1 && e1 == 0 && writes(slot_at(cfg, k), ex.rs1)) e1 = k;
        if (ex.u2 && e2 == 0 && writes(slot_at(cfg, k), ex.rs2)) e2 = k;
      end
    end
    if (cfg == 0) begin g_st = 32'(st3); g_fl = 32'(fl3); g_sv = 32'(sv3); g_f1 = 32'(f1_3); g_f2 = 32'(f2_3); end
    else          begin g_st = 32'(st5); g_fl = 32'(fl5); g_sv = 32'(sv5); g_f1 = 32'(f1_5); g_f2 = 32'(f2_5); end
    chk($sformatf("d%0d_stall", d), g_st, 32'(e_st));
    chk($sformatf("d%0d_flush", d), g_fl, 32'(e_fl));
    chk($sformatf("d%0d_slot_valid", d), g_sv, e_sv);
    chk($sformatf("d%0d_fwd_rs1", d), g_f1, 32'(e1));
    chk($sformatf("d%0d_fwd_rs2", d), g_f2, 32'(e2));
`ifdef HAZARD_PERF_EN
    chk($sformatf("d%0d_stall_cnt", d), cfg ? sc5 : sc3, 32'(cnt_st[cfg]));
    chk($sformatf("d%0d_flush_cnt", d), cfg ? fc5 : fc3, 32'(cnt_fl[cfg]));
`endif
    // advance the model across the coming edge
    nx = '0;
    if (!reset && !e_st && !e_fl && id_valid)
      nx = '{v: 1'b1, rd: int'(id_rd), we: id_we, ld: id_is_load, rs1: int'(id_rs1),
             rs2: int'(id_rs2), u1: id_rs1_used, u2: id_rs2_used};
    hist[cfg][cyc+1] = nx;
    if (reset) begin
      rst_mark[cfg] = cyc + 1;
      cnt_st[cfg] = 0;
      cnt_fl[cfg] = 0;
    end else begin
      cnt_st[cfg] += int'(e_st);
      cnt_fl[cfg] += int'(e_fl);
    end
  endtask

  task automatic apply(input bit v, input int r1, input int r2, input bit u1, input bit u2,
                       input int rd, input bit we, input bit ld, input bit rdr, input bit rst);
    id_valid = v; id_rs1 = 5'(r1); id_rs2 = 5'(r2); id_rs1_used = u1; id_rs2_used = u2;
    id_rd = 5'(rd); id_we = we; id_is_load = ld; ex_redirect = rdr; reset = rst;
    @(negedge clock);
    model_check(0);
    model_check(1);
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    cyc = 0; n_vec = 0; n_err = 0;
    for (int c = 0; c < 2; c++) begin
      rst_mark[c] = 0; cnt_st[c] = 0; cnt_fl[c] = 0; hist[c][0] = '0;
    end
    reset = 1'b1; id_valid = 1'b1; ex_redirect = 1'b0;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_we = 1'b0; id_is_load = 1'b0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    @(posedge clock);
    #1;
    // reset held with a load-use candidate in decode
    for (int i = 0; i < 3; i++) apply(1, 5, 1, 1, 1, 5, 1, 1, 1, 1);
    // lw x5 ; add x6,x5,x1 held in decode while stalled
    apply(1, 2, 0, 1, 0, 5, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) apply(1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
    nop(4);
    // add x3 ; sub x3 ; or x7,x3,x3
    apply(1, 1, 2, 1, 1, 3, 1, 0, 0, 0);
    apply(1, 1, 2, 1, 1, 3, 1, 0, 0, 0);
    apply(1, 3, 3, 1, 1, 7, 1, 0, 0, 0);
    nop(4);
    // lw x8 then dependent decode while EX redirects
    apply(1, 1, 0, 1, 0, 8, 1, 1, 0, 0);
    apply(1, 8, 8, 1, 1, 9, 1, 0, 1, 0);
    nop(3);
    // x0 never hazards nor forwards
    apply(1, 1, 2, 1, 1, 0, 1, 0, 0, 0);
    apply(1, 0, 0, 1, 1, 4, 1, 0, 0, 0);
    apply(1, 1, 0, 1, 0, 0, 1, 1, 0, 0);
    apply(1, 0, 0, 1, 1, 4, 1, 0, 0, 0);
    nop(4);
    // lw x9 then use: longer stall in the deep config
    apply(1, 1, 0, 1, 0, 9, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) apply(1, 9, 2, 1, 1, 10, 1, 0, 0, 0);
    nop(5);
    // reset mid-stall
    apply(1, 1, 0, 1, 0, 9, 1, 1, 0, 0);
    apply(1, 9, 9, 1, 1, 10, 1, 0, 0, 1);
    apply(1, 9, 9, 1, 1, 10, 1, 0, 0, 0);
    nop(3);
    // randomized traffic over a small register set to keep hazards frequent
    for (int i = 0; i < 2000; i++)
      apply($urandom_range(0, 99) < 85, $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3),
            $urandom_range(0, 9) < 8, $urandom_range(0, 99) < 35,
            $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
